// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// FSM encoding and iteration-counter sizing.
package seq_div_pkg;

    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The counter must be able to hold DVD_W itself, not just DVD_W-1.
    function automatic int cnt_width(input int dvd_w);
        return $clog2(dvd_w + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(DVD_W_DEF);

endpackage

// File: rtl/seq_divider_8_by_4_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when the partial remainder is large enough.
module div_step #(
    parameter int DVS_W = 4
) (
    input  logic [DVS_W-1:0] rem_in,
    input  logic             bit_in,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] rem_out,
    output logic             q_bit
);

    logic [DVS_W:0] partial;

    always_comb begin
        partial = {rem_in, bit_in};
        q_bit   = (partial >= {1'b0, divisor});
        // The top bit of the partial remainder is shed by the truncation in
        // both branches; for a nonzero divisor the kept value always fits.
        if (q_bit) begin
            rem_out = DVS_W'(partial - {1'b0, divisor});
        end else begin
            rem_out = DVS_W'(partial);
        end
    end

endmodule

// File: rtl/seq_divider_8_by_4.sv
// Sequential 8-by-4 restoring divider, one quotient bit per RUN cycle.
// Define SEQ_DIV_ZERO_CHECK_EN for the divide-by-zero fast path and flag.
module seq_divider_8_by_4
    import seq_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder
`ifdef SEQ_DIV_ZERO_CHECK_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int CNT_W = cnt_width(DVD_W);

    state_t           state;
    state_t           state_next;
    logic [DVD_W-1:0] dvd_r;
    logic [DVD_W-1:0] quo_acc;
    logic [DVS_W-1:0] dvs_r;
    logic [DVS_W-1:0] rem_r;
    logic [DVS_W-1:0] step_rem;
    logic             step_q;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;
    logic             zero_fast;

`ifdef SEQ_DIV_ZERO_CHECK_EN
    assign zero_fast = (divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // RUN holds one extra cycle after the last step so results land on DONE entry.
    assign last_iter = (cnt == CNT_W'(DVD_W));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    div_step #(
        .DVS_W (DVS_W)
    ) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[DVD_W-1]),
        .divisor (dvs_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = zero_fast ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r       <= '0;
            dvs_r       <= '0;
            rem_r       <= '0;
            quo_acc     <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_r   <= dividend;
                        dvs_r   <= divisor;
                        rem_r   <= '0;
                        quo_acc <= '0;
                        cnt     <= '0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                        if (zero_fast) begin
                            quotient    <= '1;
                            remainder   <= dividend[DVS_W-1:0];
                            div_by_zero <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    if (!last_iter) begin
                        rem_r   <= step_rem;
                        quo_acc <= {quo_acc[DVD_W-2:0], step_q};
                        dvd_r   <= {dvd_r[DVD_W-2:0], 1'b0};
                        cnt     <= cnt + CNT_W'(1);
                    end else begin
                        quotient    <= quo_acc;
                        remainder   <= rem_r;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
